ifetch_rom32: RTL and testbench
===============================

// Module: ifetch_rom32
// PURPOSE
//  Instruction-fetch front end driving the address port of the 32-bit ROM
//  (1-cycle registered-address read). Holds the PC and issues one word address
//  per cycle. Presents fetched words to decode through a registered
//  valid/ready interface, and handles redirects (branch/jump).
//  Full throughput: one instruction per cycle with no backpressure.
// PARAMETERS
//  DEPTH       512    ROM depth in 32-bit words; ADDR_WIDTH = $clog2(DEPTH) (localparam)
//  RESET_PC    32'h0  byte PC fetched first after reset
// PORTS
//  i_clk          in   1           clock, all state on posedge
//  i_rst_n        in   1           synchronous reset, active-low
//  o_rom_addr     out  ADDR_WIDTH  ROM word address (combinational, see below)
//  i_rom_data     in   32          ROM read data, valid 1 cycle after address
//  i_redirect     in   1           load new PC this cycle
//  i_redirect_pc  in   32          redirect byte PC
//  o_valid        out  1           o_instr/o_pc hold a fetched instruction
//  i_ready        in   1           decode accepts when o_valid && i_ready
//  o_instr        out  32          instruction word
//  o_pc           out  32          byte PC of o_instr
//  o_fault        out  1           misaligned-redirect fault (0 unless macro set)
// BEHAVIOUR
//  - State: next_pc[31:0], F1 stage {v_f1, pc_f1}, OUT reg {o_valid, o_instr, o_pc},
//    FSM {RUN, HALT}. Word index of pc = pc[ADDR_WIDTH+1:2]; upper bits ignored (wraps).
//  - Reset (i_rst_n=0 at edge): next_pc=RESET_PC, v_f1=0, pc_f1=0, o_valid=0,
//    o_instr=0, o_pc=0, o_fault=0, FSM=RUN. Reset mid-operation drops all in-flight words.
//  - stall = o_valid && !i_ready. advance = !stall.
//  - o_rom_addr mux, priority order: i_redirect -> idx(i_redirect_pc);
//    stall -> idx(pc_f1) (replay so ROM output stays stable); else idx(next_pc).
//  - RUN, i_redirect (beats stall): v_f1<=1, pc_f1<=redirect_pc, next_pc<=redirect_pc+4,
//    o_valid<=0 (OUT flushed, even if unaccepted).
//  - RUN, advance, no redirect: v_f1<=1, pc_f1<=next_pc, next_pc<=next_pc+4;
//    OUT<={v_f1, i_rom_data, pc_f1}.
//  - RUN, stall, no redirect: next_pc, F1 and OUT hold; ROM re-reads pc_f1.
//  - Latency: address issued at cycle t -> word in F1 at t+1 -> on o_valid at t+2.
//    First o_valid 2 cycles after first edge with i_rst_n=1. After redirect at t:
//    o_valid=0 at t+1, redirect target on o_valid at t+2.
//  - PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 = 0.
//  - HALT: v_f1=0 and o_valid=0 held; o_rom_addr=idx(next_pc); leave only via
//    aligned redirect (behaves as RUN redirect, FSM<=RUN) or reset.
// CONFIGURATION
//  IFETCH_ALIGN_CHECK_EN defined: redirect with i_redirect_pc[1:0]!=0 ->
//    FSM<=HALT, v_f1<=0, o_valid<=0, o_fault<=1 (sticky while HALT).
//    Cleared by aligned redirect or reset.
//  IFETCH_ALIGN_CHECK_EN undefined: i_redirect_pc[1:0] forced to 0 on load,
//    HALT unreachable, o_fault tied 0.
// TESTING
//  1 reset, RESET_PC=0, i_ready=1, ROM[n]=n -> o_valid from cycle 2,
//    o_instr 0,1,2,... one per cycle, o_pc 0,4,8,...
//  2 i_ready=0 for 3 cycles while o_pc=8 -> o_pc/o_instr hold at 8/2, o_rom_addr=3;
//    release -> 3,4 follow with no gap or duplicate.
//  3 redirect to 0x40 with o_valid=1, i_ready=0 -> o_valid=0 next cycle;
//    o_pc=0x40, o_instr=16 two cycles after redirect.
//  4 DEPTH=512, redirect to 0x7FC -> o_pc 0x7FC then 0x800, o_instr ROM[511] then ROM[0].
//  5 reset asserted mid-stream with o_valid=1 -> o_valid=0 next cycle;
//    restart from RESET_PC.
//  6 with IFETCH_ALIGN_CHECK_EN, redirect 0x42 -> o_fault=1, o_valid stays 0;
//    redirect 0x80 -> o_fault=0, o_pc=0x80 two cycles later.
//    Without macro: redirect 0x42 -> fetch 0x40.

Source files
------------

// File: rtl/ifetch_rom32.sv
// ifetch_rom32: instruction-fetch front end for a 1-cycle registered-address 32-bit ROM
// Ports: i_clk/i_rst_n (sync, active-low); o_rom_addr word address to ROM, i_rom_data word back
// one cycle later; i_redirect/i_redirect_pc load a new byte PC; o_valid/i_ready/o_instr/o_pc
// registered decode handshake; o_fault misaligned-redirect flag.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect halts fetch and raises o_fault;
// otherwise the low two redirect bits are dropped and o_fault stays 0.
module ifetch_rom32 #(
  parameter int DEPTH = 512,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [31:0]           i_rom_data,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_instr,
  output logic [31:0]           o_pc,
  output logic                  o_fault
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [31:0] next_pc, pc_f1, rpc;
  logic v_f1, stall, bad, fault_q;
  function automatic logic [ADDR_WIDTH-1:0] idx(input logic [31:0] pc);
    return pc[ADDR_WIDTH+1:2];
  endfunction
  assign stall = o_valid && !i_ready;
  assign rpc = {i_redirect_pc[31:2], 2'b00};
  // on a stall the ROM re-reads pc_f1 so its output still matches the F1 word
  assign o_rom_addr = i_redirect ? idx(i_redirect_pc) : stall ? idx(pc_f1) : idx(next_pc);
  assign o_fault = fault_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign bad = |i_redirect_pc[1:0];
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^i_redirect_pc[1:0];
  assign bad = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= RUN;
      next_pc <= RESET_PC;
      v_f1    <= 1'b0;
      pc_f1   <= 32'h0;
      o_valid <= 1'b0;
      o_instr <= 32'h0;
      o_pc    <= 32'h0;
      fault_q <= 1'b0;
    end else if (i_redirect && !bad) begin
      state   <= RUN;
      v_f1    <= 1'b1;
      pc_f1   <= rpc;
      next_pc <= rpc + 32'd4;
      o_valid <= 1'b0;
      fault_q <= 1'b0;
    end else if (i_redirect) begin
      state   <= HALT;
      v_f1    <= 1'b0;
      o_valid <= 1'b0;
      fault_q <= 1'b1;
    end else if (state == HALT) begin
      v_f1    <= 1'b0;
      o_valid <= 1'b0;
    end else if (!stall) begin
      v_f1    <= 1'b1;
      pc_f1   <= next_pc;
      next_pc <= next_pc + 32'd4;
      o_valid <= v_f1;
      o_instr <= i_rom_data;
      o_pc    <= pc_f1;
    end
  end
endmodule

// File: tb/tb_ifetch_rom32.sv
// tb_ifetch_rom32: cycle table plus accepted-word scoreboard for ifetch_rom32
module tb_ifetch_rom32;
  logic clk = 1'b0;
  logic rst_n, redir, ready, valid, fault;
  logic [31:0] rpc, rom_data, instr, pc;
  logic [8:0] rom_addr;
  int checks = 0, failures = 0, cur = 0, n_acc = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic rst_n, redir;
    logic [31:0] rpc;
    logic ready, ev;
    logic [31:0] epc;
    logic [8:0] eaddr;
    logic ef;
  } vec_t;
  vec_t tv[29];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= {23'b0, rom_addr};

  ifetch_rom32 #(.DEPTH(512), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .i_redirect(redir), .i_redirect_pc(rpc), .o_valid(valid), .i_ready(ready),
    .o_instr(instr), .o_pc(pc), .o_fault(fault)
  );

  function automatic vec_t mk(input logic r, input logic d, input logic [31:0] p, input logic y,
                              input logic e, input logic [31:0] q, input int a, input logic f);
    vec_t t;
    t.rst_n = r; t.redir = d; t.rpc = p; t.ready = y; t.ev = e; t.epc = q; t.eaddr = 9'(a); t.ef = f;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, cur, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input bit do_chk);
    logic [31:0] e;
    rst_n = t.rst_n; redir = t.redir; rpc = t.rpc; ready = t.ready;
    #1;
    if (do_chk) begin
      chk("valid", {31'b0, valid}, {31'b0, t.ev});
      if (t.ev) chk("pc", pc, t.epc);
      chk("rom_addr", {23'b0, rom_addr}, {23'b0, t.eaddr});
      chk("fault", {31'b0, fault}, {31'b0, t.ef});
    end
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) chk("sb_empty", pc, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        n_acc++;
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, {23'b0, e[10:2]});
      end
    end
    @(posedge clk);
    @(negedge clk);
    cur++;
  endtask

  initial begin
    tv[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 1, 0, 0, 1, 0);
    tv[2]  = mk(1, 0, 0, 1, 1, 32'h0, 2, 0);
    tv[3]  = mk(1, 0, 0, 1, 1, 32'h4, 3, 0);
    tv[4]  = mk(1, 0, 0, 0, 1, 32'h8, 3, 0);
    tv[5]  = mk(1, 0, 0, 0, 1, 32'h8, 3, 0);
    tv[6]  = mk(1, 0, 0, 0, 1, 32'h8, 3, 0);
    tv[7]  = mk(1, 0, 0, 1, 1, 32'h8, 4, 0);
    tv[8]  = mk(1, 0, 0, 1, 1, 32'hC, 5, 0);
    tv[9]  = mk(1, 1, 32'h40, 0, 1, 32'h10, 16, 0);
    tv[10] = mk(1, 0, 0, 1, 0, 0, 17, 0);
    tv[11] = mk(1, 0, 0, 1, 1, 32'h40, 18, 0);
    tv[12] = mk(1, 1, 32'h7FC, 1, 1, 32'h44, 511, 0);
    tv[13] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tv[14] = mk(1, 0, 0, 1, 1, 32'h7FC, 1, 0);
    tv[15] = mk(1, 0, 0, 1, 1, 32'h800, 2, 0);
    tv[16] = mk(0, 0, 0, 1, 1, 32'h804, 3, 0);
    tv[17] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tv[18] = mk(1, 0, 0, 1, 0, 0, 1, 0);
    tv[19] = mk(1, 0, 0, 1, 1, 32'h0, 2, 0);
    tv[20] = mk(1, 0, 0, 1, 1, 32'h4, 3, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    tv[21] = mk(1, 1, 32'h42, 1, 1, 32'h8, 16, 0);
    tv[22] = mk(1, 0, 0, 1, 0, 0, 4, 1);
    tv[23] = mk(1, 1, 32'h80, 1, 0, 0, 32, 1);
    tv[24] = mk(1, 0, 0, 1, 0, 0, 33, 0);
    tv[25] = mk(1, 1, 32'hFFFF_FFFC, 1, 1, 32'h80, 511, 0);
`else
    tv[21] = mk(1, 1, 32'h42, 1, 1, 32'h8, 16, 0);
    tv[22] = mk(1, 0, 0, 1, 0, 0, 17, 0);
    tv[23] = mk(1, 0, 0, 1, 1, 32'h40, 18, 0);
    tv[24] = mk(1, 0, 0, 1, 1, 32'h44, 19, 0);
    tv[25] = mk(1, 1, 32'hFFFF_FFFC, 1, 1, 32'h48, 511, 0);
`endif
    tv[26] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tv[27] = mk(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 0);
    tv[28] = mk(1, 0, 0, 1, 1, 32'h0, 2, 0);
    rst_n = 1'b0; redir = 1'b0; rpc = 32'h0; ready = 1'b1;
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    cur = 0;
    for (int i = 0; i < 29; i++) begin
      if (tv[i].rst_n && tv[i].ready && tv[i].ev) sb.push_back(tv[i].epc);
      step(tv[i], 1'b1);
    end
    chk("sb_drain", sb.size(), 0);
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    sb.delete();
    n_acc = 0;
    for (int i = 0; i < 64; i++) sb.push_back(32'(i) * 32'd4);
    for (int i = 0; i < 60; i++) step(mk(1, 0, 0, (i % 5) < 3, 0, 0, 0, 0), 1'b0);
    chk("progress", {31'b0, n_acc >= 20}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
